hamming_err_mon: RTL and testbench

HAMMING_ERR_MON -- requirements
Module: hamming_err_mon

---
 rtl/hamming_pkg.sv | 32 +++
 rtl/hamming_skid_buf.sv | 76 +++++++
 rtl/hamming_err_mon.sv | 128 ++++++++++++
 tb/tb_hamming_err_mon.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming decoder error monitor.
//   err_class_e : classification of one decoded beat by its syndrome
//   classify()  : maps a syndrome onto err_class_e for a given total codeword width
package hamming_pkg;

   // Width used to carry syndromes and codeword widths into classify()
   localparam int unsigned POS_W = 32;

   typedef enum logic [1:0] {
      CLEAN  = 2'd0,
      PAR    = 2'd1,
      CORR   = 2'd2,
      UNCORR = 2'd3
   } err_class_e;

   // Zero syndrome is clean; a single set bit points at a parity position;
   // any other in-range position is a corrected data bit; out of range is uncorrectable.
   function automatic err_class_e classify(input logic [POS_W-1:0] pos,
                                           input logic [POS_W-1:0] tw);
      err_class_e cls;
      cls = UNCORR;
      if (pos == '0) begin
         cls = CLEAN;
      end else if ((pos & (pos - POS_W'(1))) == '0) begin
         cls = PAR;
      end else if (pos <= tw) begin
         cls = CORR;
      end
      return cls;
   endfunction

endpackage

// File: rtl/hamming_skid_buf.sv
// Two-entry skid buffer: one-cycle accept-to-valid latency, full throughput,
// ready driven purely from registered occupancy.
//   i_clk, i_rstn        : clock, async active-low reset
//   i_valid/o_ready/i_data : upstream handshake and payload
//   o_valid/i_ready/o_data : downstream handshake and payload (o_data is a register)
module hamming_skid_buf #(
   parameter int unsigned W = 513
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         out_vld_q, out_vld_d;
   logic [W-1:0] out_q, out_d;
   logic         skd_vld_q, skd_vld_d;
   logic [W-1:0] skd_q, skd_d;
   logic         rdy_q, rdy_d;
   logic         accept;
   logic         deliver;

   assign accept  = i_valid && rdy_q;
   assign deliver = out_vld_q && i_ready;

   // Head register feeds the output; the skid register only fills when the head is stalled.
   always_comb begin
      out_vld_d = out_vld_q;
      out_d     = out_q;
      skd_vld_d = skd_vld_q;
      skd_d     = skd_q;
      if (!out_vld_q || deliver) begin
         if (skd_vld_q) begin
            // Skid only holds data while the head is full, and ready is low then,
            // so no new beat can arrive alongside this move.
            out_vld_d = 1'b1;
            out_d     = skd_q;
            skd_vld_d = 1'b0;
         end else begin
            out_vld_d = accept;
            if (accept) begin
               out_d = i_data;
            end
         end
      end else if (accept) begin
         skd_vld_d = 1'b1;
         skd_d     = i_data;
      end
      rdy_d = !(out_vld_d && skd_vld_d);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         out_vld_q <= 1'b0;
         out_q     <= '0;
         skd_vld_q <= 1'b0;
         skd_q     <= '0;
         rdy_q     <= 1'b0;
      end else begin
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
         skd_vld_q <= skd_vld_d;
         skd_q     <= skd_d;
         rdy_q     <= rdy_d;
      end
   end

   assign o_ready = rdy_q;
   assign o_valid = out_vld_q;
   assign o_data  = out_q;

endmodule

// File: rtl/hamming_err_mon.sv
// Pass-through monitor behind a Hamming decoder: buffers beats unchanged,
// flags uncorrectable ones, counts corrected/uncorrectable events, captures
// the first error, and raises a level interrupt.
//   i_clk, i_rstn                  : clock, async active-low reset
//   i_valid/o_ready/i_data/i_err_pos/i_addr : upstream beat
//   o_valid/i_ready/o_data/o_uncorr         : downstream beat plus sideband
//   o_corr_cnt, o_uncorr_cnt       : saturating event counters
//   o_first_vld/addr/pos           : first-error capture
//   i_clr                          : clears counters and capture
//   i_irq_en, o_irq                : interrupt enables and registered interrupt
module hamming_err_mon
   import hamming_pkg::*;
#(
   parameter int unsigned DW = 512,
   parameter int unsigned PW = 10,
   parameter int unsigned AW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   input  logic [PW-1:0] i_err_pos,
   input  logic [AW-1:0] i_addr,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic          o_uncorr,
   output logic [CW-1:0] o_corr_cnt,
   output logic [CW-1:0] o_uncorr_cnt,
   output logic          o_first_vld,
   output logic [AW-1:0] o_first_addr,
   output logic [PW-1:0] o_first_pos,
   input  logic          i_clr,
   input  logic [1:0]    i_irq_en,
   output logic          o_irq
);

   localparam int unsigned TW = DW + PW;
   localparam int unsigned SW = DW + 1;

   err_class_e    cls;
   logic          accept;
   logic          corr_evt;
   logic          uncorr_evt;
   logic [SW-1:0] skid_in;
   logic [SW-1:0] skid_out;

   logic [CW-1:0] corr_cnt_q, corr_cnt_d;
   logic [CW-1:0] uncorr_cnt_q, uncorr_cnt_d;
   logic          first_vld_q, first_vld_d;
   logic [AW-1:0] first_addr_q, first_addr_d;
   logic [PW-1:0] first_pos_q, first_pos_d;
   logic          irq_q, irq_d;

   assign cls        = classify(POS_W'(i_err_pos), POS_W'(TW));
   assign accept     = i_valid && o_ready;
   assign corr_evt   = accept && ((cls == PAR) || (cls == CORR));
   assign uncorr_evt = accept && (cls == UNCORR);
   assign skid_in    = {(cls == UNCORR), i_data};

   hamming_skid_buf #(
      .W (SW)
   ) u_skid (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (skid_in),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (skid_out)
   );

   assign o_data   = skid_out[DW-1:0];
   assign o_uncorr = skid_out[DW];

   // Clear is applied first so an event in the clear cycle lands on a fresh state.
   always_comb begin
      corr_cnt_d   = i_clr ? '0 : corr_cnt_q;
      uncorr_cnt_d = i_clr ? '0 : uncorr_cnt_q;
      first_vld_d  = i_clr ? 1'b0 : first_vld_q;
      first_addr_d = i_clr ? '0 : first_addr_q;
      first_pos_d  = i_clr ? '0 : first_pos_q;

      if (corr_evt && (corr_cnt_d != '1)) begin
         corr_cnt_d = corr_cnt_d + CW'(1);
      end
      if (uncorr_evt && (uncorr_cnt_d != '1)) begin
         uncorr_cnt_d = uncorr_cnt_d + CW'(1);
      end
      if (accept && (cls != CLEAN) && !first_vld_d) begin
         first_vld_d  = 1'b1;
         first_addr_d = i_addr;
         first_pos_d  = i_err_pos;
      end

      irq_d = (i_irq_en[0] && (corr_cnt_q != '0)) ||
              (i_irq_en[1] && (uncorr_cnt_q != '0));
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
         first_vld_q  <= 1'b0;
         first_addr_q <= '0;
         first_pos_q  <= '0;
         irq_q        <= 1'b0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
         first_vld_q  <= first_vld_d;
         first_addr_q <= first_addr_d;
         first_pos_q  <= first_pos_d;
         irq_q        <= irq_d;
      end
   end

   assign o_corr_cnt   = corr_cnt_q;
   assign o_uncorr_cnt = uncorr_cnt_q;
   assign o_first_vld  = first_vld_q;
   assign o_first_addr = first_addr_q;
   assign o_first_pos  = first_pos_q;
   assign o_irq        = irq_q;

endmodule

// File: tb/tb_hamming_err_mon.sv
// Directed bench for hamming_err_mon with default parameters.
module tb_hamming_err_mon;

   localparam int unsigned DW  = 512;
   localparam int unsigned PW  = 10;
   localparam int unsigned AW  = 32;
   localparam int unsigned CW  = 16;
   localparam int unsigned CKW = 512;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_rdy;
   logic [DW-1:0] in_data;
   logic [PW-1:0] in_pos;
   logic [AW-1:0] in_addr;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_uncorr;
   logic [CW-1:0] corr_cnt;
   logic [CW-1:0] uncorr_cnt;
   logic          first_vld;
   logic [AW-1:0] first_addr;
   logic [PW-1:0] first_pos;
   logic          clr;
   logic [1:0]    irq_en;
   logic          irq;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   hamming_err_mon #(
      .DW (DW), .PW (PW), .AW (AW), .CW (CW)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_valid      (in_valid),
      .o_ready      (in_rdy),
      .i_data       (in_data),
      .i_err_pos    (in_pos),
      .i_addr       (in_addr),
      .o_valid      (out_valid),
      .i_ready      (out_ready),
      .o_data       (out_data),
      .o_uncorr     (out_uncorr),
      .o_corr_cnt   (corr_cnt),
      .o_uncorr_cnt (uncorr_cnt),
      .o_first_vld  (first_vld),
      .o_first_addr (first_addr),
      .o_first_pos  (first_pos),
      .i_clr        (clr),
      .i_irq_en     (irq_en),
      .o_irq        (irq)
   );

   function automatic logic [DW-1:0] pat(input logic [31:0] k);
      logic [31:0] w;
      w = k ^ 32'hA5A5_0000;
      return {16{w}};
   endfunction

   task automatic chk(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PW-1:0] pos, input logic [AW-1:0] addr,
                        input logic [31:0] k);
      in_valid = v;
      in_pos   = pos;
      in_addr  = addr;
      in_data  = pat(k);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn      = 1'b0;
      clr       = 1'b0;
      irq_en    = 2'b00;
      out_ready = 1'b0;
      drive(1'b0, '0, '0, 32'd0);

      // Reset state
      cyc(); cyc();
      chk("rst_valid",      CKW'(out_valid),  CKW'(1'b0));
      chk("rst_ready",      CKW'(in_rdy),     CKW'(1'b0));
      chk("rst_corr_cnt",   CKW'(corr_cnt),   CKW'(0));
      chk("rst_uncorr_cnt", CKW'(uncorr_cnt), CKW'(0));
      chk("rst_first_vld",  CKW'(first_vld),  CKW'(1'b0));
      chk("rst_first_addr", CKW'(first_addr), CKW'(0));
      chk("rst_first_pos",  CKW'(first_pos),  CKW'(0));
      chk("rst_irq",        CKW'(irq),        CKW'(1'b0));
      chk("rst_uncorr",     CKW'(out_uncorr), CKW'(1'b0));
      rstn = 1'b1;
      #1;
      chk("rel_ready_pre",  CKW'(in_rdy),     CKW'(1'b0));
      cyc();
      chk("rel_ready_post", CKW'(in_rdy),     CKW'(1'b1));

      // Clean stream of 8 beats at full throughput
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, '0, AW'(k), 32'(k));
         cyc();
         chk("clean_valid", CKW'(out_valid),  CKW'(1'b1));
         chk("clean_data",  CKW'(out_data),   CKW'(pat(32'(k))));
         chk("clean_unc",   CKW'(out_uncorr), CKW'(1'b0));
         chk("clean_ready", CKW'(in_rdy),     CKW'(1'b1));
      end
      drive(1'b0, '0, '0, 32'd0);
      cyc();
      chk("clean_drain",  CKW'(out_valid), CKW'(1'b0));
      chk("clean_corr",   CKW'(corr_cnt),  CKW'(0));
      chk("clean_uncorr", CKW'(uncorr_cnt), CKW'(0));
      chk("clean_first",  CKW'(first_vld), CKW'(1'b0));

      // Corrected errors and first-error capture
      drive(1'b1, PW'(3), AW'(32'h100), 32'h10);
      cyc();
      chk("c1_corr",  CKW'(corr_cnt),  CKW'(1));
      chk("c1_first", CKW'(first_vld), CKW'(1'b1));
      drive(1'b1, PW'(5), AW'(32'h200), 32'h11);
      cyc();
      chk("c2_corr",  CKW'(corr_cnt),   CKW'(2));
      chk("c2_faddr", CKW'(first_addr), CKW'(32'h100));
      chk("c2_fpos",  CKW'(first_pos),  CKW'(3));
      chk("c2_data",  CKW'(out_data),   CKW'(pat(32'h11)));
      // 512 is a parity position, 522 the last in-range position
      drive(1'b1, PW'(512), AW'(32'h210), 32'h12);
      cyc();
      chk("par_corr", CKW'(corr_cnt), CKW'(3));
      drive(1'b1, PW'(522), AW'(32'h220), 32'h13);
      cyc();
      chk("tw_corr",   CKW'(corr_cnt),   CKW'(4));
      chk("tw_uncorr", CKW'(uncorr_cnt), CKW'(0));
      chk("tw_flag",   CKW'(out_uncorr), CKW'(1'b0));
      chk("tw_faddr",  CKW'(first_addr), CKW'(32'h100));
      chk("tw_irq",    CKW'(irq),        CKW'(1'b0));
      drive(1'b0, '0, '0, 32'd0);

      // Clear
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_corr",  CKW'(corr_cnt),   CKW'(0));
      chk("clr_first", CKW'(first_vld),  CKW'(1'b0));
      chk("clr_faddr", CKW'(first_addr), CKW'(0));
      chk("clr_fpos",  CKW'(first_pos),  CKW'(0));

      // Uncorrectable beats and interrupt
      irq_en = 2'b10;
      drive(1'b1, PW'(600), AW'(32'h300), 32'h55);
      cyc();
      chk("u1_valid",  CKW'(out_valid),  CKW'(1'b1));
      chk("u1_flag",   CKW'(out_uncorr), CKW'(1'b1));
      chk("u1_data",   CKW'(out_data),   CKW'(pat(32'h55)));
      chk("u1_cnt",    CKW'(uncorr_cnt), CKW'(1));
      chk("u1_corr",   CKW'(corr_cnt),   CKW'(0));
      chk("u1_faddr",  CKW'(first_addr), CKW'(32'h300));
      chk("u1_fpos",   CKW'(first_pos),  CKW'(600));
      drive(1'b1, PW'(523), AW'(32'h301), 32'h56);
      cyc();
      chk("u2_flag",   CKW'(out_uncorr), CKW'(1'b1));
      chk("u2_cnt",    CKW'(uncorr_cnt), CKW'(2));
      chk("u2_irq",    CKW'(irq),        CKW'(1'b1));
      chk("u2_fpos",   CKW'(first_pos),  CKW'(600));
      drive(1'b0, '0, '0, 32'd0);
      irq_en = 2'b01;
      cyc();
      chk("irq_mask",  CKW'(irq),        CKW'(1'b0));
      chk("u_drain",   CKW'(out_valid),  CKW'(1'b0));

      // Backpressure: two beats buffered, order kept after release
      out_ready = 1'b0;
      drive(1'b1, '0, AW'(32'hA0), 32'hA0);
      cyc();
      chk("bp0_valid", CKW'(out_valid), CKW'(1'b1));
      chk("bp0_data",  CKW'(out_data),  CKW'(pat(32'hA0)));
      chk("bp0_ready", CKW'(in_rdy),    CKW'(1'b1));
      drive(1'b1, PW'(600), AW'(32'hA1), 32'hA1);
      cyc();
      chk("bp1_ready", CKW'(in_rdy),    CKW'(1'b0));
      chk("bp1_data",  CKW'(out_data),  CKW'(pat(32'hA0)));
      drive(1'b1, '0, AW'(32'hA2), 32'hA2);
      cyc();
      chk("bp2_ready", CKW'(in_rdy),     CKW'(1'b0));
      chk("bp2_data",  CKW'(out_data),   CKW'(pat(32'hA0)));
      chk("bp2_flag",  CKW'(out_uncorr), CKW'(1'b0));
      cyc();
      chk("bp3_ready", CKW'(in_rdy),    CKW'(1'b0));
      chk("bp3_data",  CKW'(out_data),  CKW'(pat(32'hA0)));
      out_ready = 1'b1;
      cyc();
      chk("rel1_valid", CKW'(out_valid),  CKW'(1'b1));
      chk("rel1_data",  CKW'(out_data),   CKW'(pat(32'hA1)));
      chk("rel1_flag",  CKW'(out_uncorr), CKW'(1'b1));
      chk("rel1_ready", CKW'(in_rdy),     CKW'(1'b1));
      cyc();
      chk("rel2_data",  CKW'(out_data),   CKW'(pat(32'hA2)));
      chk("rel2_flag",  CKW'(out_uncorr), CKW'(1'b0));
      drive(1'b0, '0, '0, 32'd0);
      cyc();
      chk("rel3_valid", CKW'(out_valid), CKW'(1'b0));

      // Saturation, then clear coinciding with an error beat
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      drive(1'b1, PW'(3), AW'(32'h400), 32'h40);
      repeat (65535) cyc();
      chk("sat_full",  CKW'(corr_cnt), CKW'(16'hFFFF));
      chk("sat_irq",   CKW'(irq),      CKW'(1'b1));
      cyc();
      chk("sat_hold",  CKW'(corr_cnt), CKW'(16'hFFFF));
      clr = 1'b1;
      drive(1'b1, PW'(3), AW'(32'h500), 32'h50);
      cyc();
      clr = 1'b0;
      chk("clrevt_cnt",   CKW'(corr_cnt),   CKW'(1));
      chk("clrevt_fvld",  CKW'(first_vld),  CKW'(1'b1));
      chk("clrevt_faddr", CKW'(first_addr), CKW'(32'h500));
      chk("clrevt_fpos",  CKW'(first_pos),  CKW'(3));
      drive(1'b0, '0, '0, 32'd0);
      cyc();

      // Reset with two beats buffered
      out_ready = 1'b0;
      drive(1'b1, PW'(5), AW'(32'h600), 32'h60);
      cyc();
      drive(1'b1, PW'(5), AW'(32'h601), 32'h61);
      cyc();
      drive(1'b0, '0, '0, 32'd0);
      chk("pre_rst_cnt",   CKW'(corr_cnt),  CKW'(3));
      chk("pre_rst_ready", CKW'(in_rdy),    CKW'(1'b0));
      chk("pre_rst_valid", CKW'(out_valid), CKW'(1'b1));
      #2;
      rstn = 1'b0;
      #1;
      chk("mr_valid",  CKW'(out_valid),  CKW'(1'b0));
      chk("mr_ready",  CKW'(in_rdy),     CKW'(1'b0));
      chk("mr_corr",   CKW'(corr_cnt),   CKW'(0));
      chk("mr_uncorr", CKW'(uncorr_cnt), CKW'(0));
      chk("mr_first",  CKW'(first_vld),  CKW'(1'b0));
      chk("mr_irq",    CKW'(irq),        CKW'(1'b0));
      cyc();
      out_ready = 1'b1;
      rstn = 1'b1;
      cyc();
      chk("mr_rel_ready", CKW'(in_rdy),    CKW'(1'b1));
      chk("mr_rel_valid", CKW'(out_valid), CKW'(1'b0));
      cyc();
      chk("mr_no_deliv",  CKW'(out_valid), CKW'(1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
